// File: rtl/mmm_ctrl_pkg.sv
// Shared types and default sizes for the Montgomery multiplier controller
// and the datapath blocks it sequences.
package mmm_ctrl_pkg;

    // Default operand width; also the number of Montgomery iterations.
    localparam int unsigned MmmWidth = 10;
    // Default width of the multiplier bit index (2**MmmIdxW >= MmmWidth).
    localparam int unsigned MmmIdxW  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StIter,
        StCorrect,
        StDone
    } mmm_state_e;

endpackage

// File: rtl/mmm_ctrl_if.sv
// Handshake and datapath-control bundle between a host, the controller and
// the external R register / adder.
interface mmm_ctrl_if
    import mmm_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = MmmIdxW
) ();

    logic             en;
    logic             start;
    logic             abort;
    logic             r_ge_m;
    logic             rst_mmm_o;
    logic             ld_r;
    logic             lock;
    logic [IDX_W-1:0] bit_idx;
    logic             busy;
    logic             done;

    // Host side: issues requests and supplies the datapath compare result.
    modport master (
        output en, start, abort, r_ge_m,
        input  rst_mmm_o, ld_r, lock, bit_idx, busy, done
    );

    // Controller side.
    modport slave (
        input  en, start, abort, r_ge_m,
        output rst_mmm_o, ld_r, lock, bit_idx, busy, done
    );

endinterface

// File: rtl/mmm_iter_cnt.sv
// Iteration counter: synchronous clear, increment enable, saturates at the
// terminal count WIDTH-1 so it can never wrap past the last iteration.
module mmm_iter_cnt
    import mmm_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = MmmWidth,
    parameter int unsigned IDX_W = MmmIdxW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] cnt,
    output logic             tc
);

    localparam logic [IDX_W-1:0] Last = IDX_W'(WIDTH - 1);

    logic [IDX_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over increment; hold at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !tc) begin
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == Last);

endmodule

// File: rtl/mmm_ctrl.sv
// Montgomery modular multiplication sequencer. Drives the clear, load and
// correction-select strobes of an external R register / adder; holds no
// datapath state of its own.
module mmm_ctrl
    import mmm_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = MmmWidth,
    parameter int unsigned IDX_W = MmmIdxW
) (
    input  logic       clk,
    input  logic       rst,
    mmm_ctrl_if.slave  bus
);

    mmm_state_e       state_q, state_d;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc;
    logic [IDX_W-1:0] cnt;

    // State register; reset overrides en and abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; nothing moves unless en is high, abort beats everything.
    always_comb begin
        state_d = state_q;
        if (bus.en) begin
            if (bus.abort) begin
                state_d = StIdle;
            end else begin
                unique case (state_q)
                    StIdle:    if (bus.start) state_d = StClear;
                    StClear:   state_d = StIter;
                    StIter:    if (cnt_tc) state_d = StCorrect;
                    StCorrect: state_d = StDone;
                    StDone:    state_d = StIdle;
                    default:   state_d = StIdle;
                endcase
            end
        end
    end

    // Counter control: advance only while staying in ITER, otherwise clear
    // so every non-ITER state (including after abort) shows bit_idx = 0.
    always_comb begin
        cnt_clr = bus.en && (state_d != StIter);
        cnt_inc = bus.en && (state_q == StIter) && (state_d == StIter);
    end

    mmm_iter_cnt #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_iter_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    // Outputs decoded from state; lock is the only path from r_ge_m.
    always_comb begin
        bus.rst_mmm_o = 1'b1;
        bus.ld_r      = 1'b0;
        bus.lock      = 1'b0;
        bus.busy      = (state_q != StIdle);
        bus.done      = 1'b0;
        bus.bit_idx   = cnt;
        unique case (state_q)
            StIdle:    ;
            StClear:   bus.rst_mmm_o = 1'b0;
            StIter:    bus.ld_r = 1'b1;
            StCorrect: begin
                bus.ld_r = 1'b1;
                bus.lock = bus.r_ge_m;
            end
            StDone:    bus.done = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_mmm_ctrl.sv
// Directed, table-driven bench for mmm_ctrl (WIDTH=10, IDX_W=4), plus a
// hand-written back-to-back run with start held high.
module tb_mmm_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mmm_ctrl_if #(.IDX_W(4)) bus ();

    mmm_ctrl #(
        .WIDTH (10),
        .IDX_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // exp = {rst_mmm_o, ld_r, lock, bit_idx[3:0], busy, done} after the edge
    typedef struct {
        logic       rst;
        logic       en;
        logic       start;
        logic       abort;
        logic       rgm;
        logic [8:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic r, input logic e, input logic s, input logic a,
                       input logic g, input logic rmm, input logic ld, input logic lk,
                       input int idx, input logic bsy, input logic dn);
        vec_t v;
        v.rst   = r;
        v.en    = e;
        v.start = s;
        v.abort = a;
        v.rgm   = g;
        v.exp   = {rmm, ld, lk, 4'(idx), bsy, dn};
        vq.push_back(v);
    endtask

    task automatic add_idle(input logic r, input logic e, input logic s, input logic a);
        add(r, e, s, a, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Complete run: start edge, CLEAR, 10x ITER, CORRECT, DONE, back to IDLE.
    task automatic add_run(input logic g, input logic busy_start);
        add(0, 1, 1, 0, g, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) add(0, 1, busy_start, 0, g, 1, 1, 0, i, 1, 0);
        add(0, 1, busy_start, 0, g, 1, 1, g, 0, 1, 0);
        add(0, 1, 0, 0, g, 1, 0, 0, 0, 1, 1);
        add_idle(0, 1, 0, 0);
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b (rmm,ld,lock,idx,busy,done)",
                     name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {bus.rst_mmm_o, bus.ld_r, bus.lock, bus.bit_idx, bus.busy, bus.done};
    endfunction

    int t_done[3];
    int n_done;
    int gap;

    initial begin
        bus.en     = 1'b0;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.r_ge_m = 1'b0;

        // Reset (also with en low and abort/start high), idle holds.
        add_idle(1, 1, 0, 0);
        add_idle(1, 0, 1, 1);
        add_idle(0, 1, 0, 0);
        add_idle(0, 0, 1, 0);
        add_idle(0, 1, 1, 1);

        // Basic run, then correction run with start held while busy.
        add_run(1'b0, 1'b0);
        add_run(1'b1, 1'b1);

        // Stall 3 cycles at bit_idx=4, then hold an active done with en low.
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i <= 4; i++) add(0, 1, 0, 0, 0, 1, 1, 0, i, 1, 0);
        for (int i = 0; i < 3; i++)  add(0, 0, 0, 0, 0, 1, 1, 0, 4, 1, 0);
        for (int i = 5; i < 10; i++) add(0, 1, 0, 0, 0, 1, 1, 0, i, 1, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1);
        add_idle(0, 1, 0, 0);

        // Abort at bit_idx=6 (first with en low, which must hold); CLEAR
        // also held by en low. Then a fresh run.
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i <= 6; i++) add(0, 1, 0, 0, 0, 1, 1, 0, i, 1, 0);
        add(0, 0, 0, 1, 0, 1, 1, 0, 6, 1, 0);
        add_idle(0, 1, 0, 1);
        add_idle(0, 1, 0, 0);
        add_run(1'b0, 1'b0);

        // Reset at bit_idx=3 with en low and start high, then a fresh run.
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i <= 3; i++) add(0, 1, 1, 0, 0, 1, 1, 0, i, 1, 0);
        add_idle(1, 0, 1, 0);
        add_idle(0, 1, 0, 0);
        add_run(1'b1, 1'b0);

        // Abort on the last iteration: beats the move to CORRECT, no done.
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 1, 1, 1, 0, i, 1, 0);
        add_idle(0, 1, 0, 1);
        add_idle(0, 1, 0, 0);

        foreach (vq[k]) begin
            @(negedge clk);
            rst        = vq[k].rst;
            bus.en     = vq[k].en;
            bus.start  = vq[k].start;
            bus.abort  = vq[k].abort;
            bus.r_ge_m = vq[k].rgm;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), outs(), vq[k].exp);
        end

        // Back-to-back with start held: IDLE visited once between runs, so
        // done pulses are 14 edges apart (13 cycles strictly between them).
        @(negedge clk);
        rst        = 1'b0;
        bus.en     = 1'b1;
        bus.start  = 1'b1;
        bus.abort  = 1'b0;
        bus.r_ge_m = 1'b0;
        n_done = 0;
        gap    = 0;
        for (int cyc = 1; cyc <= 60 && n_done < 3; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                t_done[n_done] = cyc;
                n_done++;
            end else if (n_done == 1 && !bus.busy) begin
                gap++;
            end
        end
        check_int("b2b_done_count", n_done, 3);
        if (n_done == 3) begin
            check_int("b2b_period1", t_done[1] - t_done[0], 14);
            check_int("b2b_period2", t_done[2] - t_done[1], 14);
            check_int("b2b_first_done", t_done[0], 13);
        end
        check_int("b2b_idle_gap", gap, 1);

        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_final_idle", outs(), 9'b1_0_0_0000_0_0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
